// File: rtl/uart_rx_fifo_pkg.sv
// Shared constants for the UART receive buffer.
// The character width is the only value shared between the wrapper and its bench-facing ports.
package uart_rx_fifo_pkg;
    localparam int CHAR_WIDTH = 8;
endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// Generic single-clock FIFO: storage array, wrapping pointers and a separate occupancy counter.
// Flush overrides push and pop. Full and empty come from the counter, not from pointer compare.
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);
    localparam logic [AW:0] COUNT_MAX = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && !flush && (count_q != '0);
    assign do_push = push && !flush && ((count_q != COUNT_MAX) || do_pop);

    // Storage is deliberately left unreset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_data = mem[rd_ptr];
    assign count     = count_q;
    assign full      = (count_q == COUNT_MAX);
    assign empty     = (count_q == '0);
endmodule

// File: rtl/uart_rx_fifo.sv
// Receive buffer behind the UART receiver: first-word-fall-through FIFO with a sticky overrun flag.
// The receiver cannot stall, so a character arriving at a full FIFO without a same-cycle read is dropped.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter  int FIFO_DEPTH = 8,
    localparam int ADDR_WIDTH = $clog2(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [CHAR_WIDTH-1:0] rx_char,
    input  logic                  rx_char_valid,
    input  logic                  rd_en,
    output logic [CHAR_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic [ADDR_WIDTH:0]   fifo_count,
    output logic                  full,
    output logic                  overrun,
    input  logic                  clear_overrun,
    input  logic                  flush
);
    logic [CHAR_WIDTH-1:0] head_data;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic                  overrun_set;

    assign pop  = rd_en && !empty;
    // A read in the same cycle frees the slot, so a full FIFO still accepts the character.
    assign push = rx_char_valid && (!full || rd_en);
    assign overrun_set = rx_char_valid && full && !rd_en && !flush;

    sync_fifo #(
        .WIDTH (CHAR_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (rx_char),
        .pop       (pop),
        .flush     (flush),
        .head_data (head_data),
        .full      (full),
        .empty     (empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overrun <= 1'b0;
        end else if (overrun_set) begin
            overrun <= 1'b1;
        end else if (clear_overrun) begin
            overrun <= 1'b0;
        end
    end

    assign rd_valid = !empty;
    assign rd_data  = empty ? '0 : head_data;
endmodule
